uart_rx_byte: RTL

Host-side UART receiver sitting directly upstream of the perceptron core. It deserialises the 8N1 `host_tx` line from the host into bytes and presents each byte on a valid/ready interface to the perceptron's command/input logic. It oversamples at the system clock: 50 MHz, with default timing for 115200 baud. It rejects start-bit glitches and flags framing and overrun errors.

---
 rtl/uart_rx_byte_if.sv | 24 ++
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_rx_byte_if.sv
// Byte handshake bundle between the UART receiver and its consumer.
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : byte available, held until accepted
//   rx_ready  : consumer accepts on a rising edge with rx_valid high
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while rx_valid was high
// master = receiver side, slave = consumer side.
interface uart_rx_byte_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data, rx_valid, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver oversampled at the system clock. Deserialises host_tx
// into bytes and offers them on a valid/ready handshake, rejecting short
// start-bit glitches and flagging framing and overrun errors.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   host_tx : asynchronous serial line, idles high
//   rx      : byte handshake (master side of uart_rx_byte_if)
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | line high, waiting for a falling start edge
// START     | half a bit in, re-check start bit (glitch filter)
// DATA      | sampling 8 data bits LSB first, one per bit time
// STOP      | sampling stop bit, deliver byte or flag error
// WAIT_HIGH | stop bit was low, hold off until the line returns high
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           host_tx,
  uart_rx_byte_if.master rx
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  logic [1:0]  sync;
  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bitcnt;
  logic [7:0]  shift;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= 2'b11;
      state        <= IDLE;
      cnt          <= '0;
      bitcnt       <= '0;
      shift        <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      sync         <= {sync[0], host_tx};
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;

      // Acceptance clears valid; a byte landing on the same edge below
      // overrides this and keeps valid high with the new data.
      if (rx.rx_valid && rx.rx_ready)
        rx.rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s)
            state <= START;
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state  <= DATA;
              bitcnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt           <= '0;
            shift[bitcnt] <= rx_s;
            bitcnt        <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!rx.rx_valid || rx.rx_ready) begin
                rx.rx_data  <= shift;
                rx.rx_valid <= 1'b1;
              end else begin
                rx.overrun <= 1'b1;
              end
            end else begin
              rx.frame_err <= 1'b1;
              state        <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s)
            state <= IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
